sync_reset_reg_bank: RTL and testbench
======================================

// Module: sync_reset_reg_bank
// PURPOSE
//  Parametrised bank of NUM_REGS x WIDTH enable-gated registers with synchronous reset to RESET_VALUE.
//  Supports masked write/set/clear/toggle ops, per-register sticky lock, and 1-cycle fetch-style response.
//  Every register is also exposed flat on q for direct control fan-out.
//  Sits between a simple request master (CSR decoder, debug module) and downstream control logic.
// PARAMETERS
//  WIDTH        8    bits per register (>=1)
//  NUM_REGS     4    number of registers (>=1, need not be a power of 2)
//  RESET_VALUE  '0   WIDTH-bit value loaded into every register on reset
//  AW (local)   $clog2(NUM_REGS) rounded up to >=1; address width
// PORTS
//  clk         in   1               clock; all state updates on posedge
//  rst         in   1               reset, synchronous, active-high
//  req_valid   in   1               request strobe; always accepted, no back-pressure
//  req_op      in   3               0 READ,1 WRITE,2 SET,3 CLEAR,4 TOGGLE,5 LOCK,6-7 reserved
//  req_addr    in   AW              target register index
//  req_data    in   WIDTH           operand
//  req_mask    in   WIDTH           per-bit enable for data ops
//  resp_valid  out  1               pulses exactly 1 cycle after each accepted request
//  resp_data   out  WIDTH           target register value BEFORE the op (0 on error to bad addr)
//  resp_err    out  1               valid with resp_valid; see error rules
//  q           out  NUM_REGS*WIDTH  current register contents, reg i at [i*WIDTH +: WIDTH]
//  locked      out  NUM_REGS        per-register lock state
//  parity_err  out  NUM_REGS        sticky stored-parity mismatch flag (0 without the macro)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all regs<=RESET_VALUE, locked<=0, parity_err<=0, resp_valid<=0,
//    resp_data<=0, resp_err<=0. rst beats any req_valid in the same cycle (request dropped, no resp).
//  - Request accepted when req_valid=1 and rst=0; effect visible on q the following cycle.
//  - m = req_data & req_mask. WRITE: r<=(r&~req_mask)|m; SET: r<=r|m; CLEAR: r<=r&~m; TOGGLE: r<=r^m.
//  - LOCK: locked[a]<=1, data/mask ignored; only reset clears a lock. LOCK on locked reg: no-op, no err.
//  - READ: no state change. READ on locked reg is legal.
//  - Errors (resp_err=1, no state change): req_addr>=NUM_REGS; req_op 6/7; data op on locked reg.
//  - Latency: resp fields registered, 1 cycle. Back-to-back requests to same addr: 2nd sees 1st's result
//    (register already updated at the edge; no forwarding path needed).
//  - Zero mask data op: no change, no error, resp returned normally.
//  - req_valid=0: registers hold; resp_valid=0, resp_data/resp_err hold previous values.
// CONFIGURATION
//  SYNC_RESET_REG_BANK_PARITY_EN defined: one even-parity bit stored per register, recomputed on every
//    reset and every modifying op. Any access (incl. READ) whose stored parity mismatches sets
//    parity_err[a] (sticky until reset) and resp_err=1 for that response; op still executes.
//  Not defined: no parity storage; parity_err tied to 0; resp_err never set by parity.
// STRUCTURE
//  Package sync_reset_reg_bank_pkg: op enum (OP_READ..OP_LOCK), apply_op() function returning next
//    value from (cur,data,mask,op), even-parity function.
//  Sub-module sync_reset_reg_cell: one WIDTH register + lock bit + optional parity bit, with
//    synchronous reset and write-enable; bank generates NUM_REGS instances plus request decode/resp regs.
// TESTING
//  1 Reset, WIDTH=8, RESET_VALUE=8'hA5: q all 8'hA5, locked=0, resp_valid=0 after release.
//  2 WRITE a=1 data=FF mask=0F, then READ a=1 -> resp_data=A5 then AF; SET a=1 d=50 m=F0 -> AF then FF.
//  3 LOCK a=2, then WRITE a=2 d=00 m=FF -> resp_err=1, q reg2 stays A5; READ a=2 -> err=0, data=A5.
//  4 NUM_REGS=3: READ a=3 -> resp_err=1, resp_data=0; op 7 a=0 -> resp_err=1, reg0 unchanged.
//  5 req_valid and rst both high -> no resp next cycle, all regs A5; lock from step 3 cleared.
//  6 PARITY_EN: force stored parity of reg0, READ a=0 -> resp_err=1, parity_err[0]=1 until rst.

Source files
------------

// File: rtl/sync_reset_reg_bank_pkg.sv
// rtl/sync_reset_reg_bank_pkg.sv - op encoding and datapath helpers for the register bank
package sync_reset_reg_bank_pkg;

    // Widest register the helper functions handle; callers zero-extend into this width.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_READ   = 3'd0,
        OP_WRITE  = 3'd1,
        OP_SET    = 3'd2,
        OP_CLEAR  = 3'd3,
        OP_TOGGLE = 3'd4,
        OP_LOCK   = 3'd5
    } op_e;

    // Ops that modify register contents and are therefore refused on a locked register.
    function automatic logic is_data_op(input logic [2:0] op);
        return (op == OP_WRITE) || (op == OP_SET) || (op == OP_CLEAR) || (op == OP_TOGGLE);
    endfunction

    // Next register value for a masked data op; non-data ops leave the value unchanged.
    function automatic logic [MAX_WIDTH-1:0] apply_op(
        input logic [MAX_WIDTH-1:0] cur,
        input logic [MAX_WIDTH-1:0] data,
        input logic [MAX_WIDTH-1:0] mask,
        input logic [2:0]           op
    );
        logic [MAX_WIDTH-1:0] m;
        m = data & mask;
        case (op)
            OP_WRITE:  return (cur & ~mask) | m;
            OP_SET:    return cur | m;
            OP_CLEAR:  return cur & ~m;
            OP_TOGGLE: return cur ^ m;
            default:   return cur;
        endcase
    endfunction

    // Even-parity bit: value plus this bit always holds an even number of ones.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sync_reset_reg_cell.sv
// rtl/sync_reset_reg_cell.sv - one register with sticky lock and optional parity (SYNC_RESET_REG_BANK_PARITY_EN)
module sync_reset_reg_cell
    import sync_reset_reg_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             lock_set_i,
    input  logic             access_i,
    output logic [WIDTH-1:0] value_o,
    output logic             locked_o,
    output logic             par_bad_o,
    output logic             perr_o
);

    logic [WIDTH-1:0] value_q;
    logic             locked_q;

    // Register contents: reset value, else load on an accepted data op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= RESET_VALUE;
        end else if (wr_en_i) begin
            value_q <= wr_data_i;
        end
    end

    // Lock is sticky; only reset releases it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q <= 1'b0;
        end else if (lock_set_i) begin
            locked_q <= 1'b1;
        end
    end

    assign value_o  = value_q;
    assign locked_o = locked_q;

`ifdef SYNC_RESET_REG_BANK_PARITY_EN
    logic par_q;
    logic perr_q;

    // Stored parity tracks every value load so a later flip of either is detectable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_q <= even_parity(MAX_WIDTH'(RESET_VALUE));
        end else if (wr_en_i) begin
            par_q <= even_parity(MAX_WIDTH'(wr_data_i));
        end
    end

    assign par_bad_o = (par_q != even_parity(MAX_WIDTH'(value_q)));

    // Mismatch is latched only when someone actually touches the register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perr_q <= 1'b0;
        end else if (access_i && par_bad_o) begin
            perr_q <= 1'b1;
        end
    end

    assign perr_o = perr_q;
`else
    logic unused_access;
    assign unused_access = access_i;
    assign par_bad_o     = 1'b0;
    assign perr_o        = 1'b0;
`endif

endmodule

// File: rtl/sync_reset_reg_bank.sv
// rtl/sync_reset_reg_bank.sv - masked-op register bank with lock and 1-cycle response (SYNC_RESET_REG_BANK_PARITY_EN)
module sync_reset_reg_bank
    import sync_reset_reg_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               NUM_REGS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [2:0]                req_op,
    input  logic [AW-1:0]             req_addr,
    input  logic [WIDTH-1:0]          req_data,
    input  logic [WIDTH-1:0]          req_mask,
    output logic                      resp_valid,
    output logic [WIDTH-1:0]          resp_data,
    output logic                      resp_err,
    output logic [NUM_REGS*WIDTH-1:0] q,
    output logic [NUM_REGS-1:0]       locked,
    output logic [NUM_REGS-1:0]       parity_err
);

    logic [WIDTH-1:0]    cell_value [NUM_REGS];
    logic [NUM_REGS-1:0] cell_locked;
    logic [NUM_REGS-1:0] cell_par_bad;
    logic [NUM_REGS-1:0] sel;

    logic [WIDTH-1:0] cur_value;
    logic             cur_locked;
    logic             cur_par_bad;
    logic             addr_ok;
    logic             op_known;
    logic             data_op;
    logic             exec_err;
    logic             par_err_now;
    logic             accept;
    logic             wr_go;
    logic             lock_go;
    logic [WIDTH-1:0] next_value;

    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    // Address decode and read mux; an out-of-range address selects nothing and reads as 0.
    always_comb begin
        sel         = '0;
        cur_value   = '0;
        cur_locked  = 1'b0;
        cur_par_bad = 1'b0;
        addr_ok     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == AW'(i)) begin
                sel[i]      = 1'b1;
                cur_value   = cell_value[i];
                cur_locked  = cell_locked[i];
                cur_par_bad = cell_par_bad[i];
                addr_ok     = 1'b1;
            end
        end
    end

    // Request classification: execution errors block the op, a parity hit only flags it.
    always_comb begin
        op_known    = (req_op <= OP_LOCK);
        data_op     = is_data_op(req_op);
        exec_err    = !addr_ok || !op_known || (data_op && cur_locked);
        par_err_now = addr_ok && cur_par_bad;
        accept      = req_valid && !rst;
        wr_go       = accept && data_op && !exec_err;
        lock_go     = accept && addr_ok && (req_op == OP_LOCK);
        next_value  = WIDTH'(apply_op(MAX_WIDTH'(cur_value), MAX_WIDTH'(req_data),
                                      MAX_WIDTH'(req_mask), req_op));
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
            sync_reset_reg_cell #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_cell (
                .clk_i      (clk),
                .rst_i      (rst),
                .wr_en_i    (wr_go && sel[gi]),
                .wr_data_i  (next_value),
                .lock_set_i (lock_go && sel[gi]),
                .access_i   (accept && sel[gi]),
                .value_o    (cell_value[gi]),
                .locked_o   (cell_locked[gi]),
                .par_bad_o  (cell_par_bad[gi]),
                .perr_o     (parity_err[gi])
            );
            assign q[gi*WIDTH +: WIDTH] = cell_value[gi];
        end
    endgenerate

    assign locked = cell_locked;

    // Response next-state: capture pre-op value and error on a request, otherwise hold.
    always_comb begin
        resp_valid_d = req_valid;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (req_valid) begin
            resp_data_d = cur_value;
            resp_err_d  = exec_err || par_err_now;
        end
    end

    // Response registers; reset drops any request presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_sync_reset_reg_bank.sv
// tb/tb_sync_reset_reg_bank.sv - directed plus random checks against a behavioural bank model
module tb_sync_reset_reg_bank;

    localparam int         W  = 8;
    localparam int         N  = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [2:0]   req_op = 3'd0;
    logic [1:0]   req_addr = 2'd0;
    logic [7:0]   req_data = 8'd0;
    logic [7:0]   req_mask = 8'd0;
    logic         resp_valid;
    logic [7:0]   resp_data;
    logic         resp_err;
    logic [23:0]  q;
    logic [2:0]   locked;
    logic [2:0]   parity_err;

    sync_reset_reg_bank #(
        .WIDTH       (W),
        .NUM_REGS    (N),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .q          (q),
        .locked     (locked),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mreg  [N];
    logic       mlock [N];
    logic       mperr [N];
    logic       mpbad [N];
    logic       armed  = 1'b0;
    logic       exp_rv = 1'b0;
    logic [7:0] exp_rd = 8'd0;
    logic       exp_re = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [23:0] mq;
        logic [2:0]  ml;
        logic [2:0]  mp;
        for (int i = 0; i < N; i++) begin
            mq[i*8 +: 8] = mreg[i];
            ml[i]        = mlock[i];
            mp[i]        = mperr[i];
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_data",  32'(resp_data),  32'(exp_rd));
        chk("resp_err",   32'(resp_err),   32'(exp_re));
        chk("q",          32'(q),          32'(mq));
        chk("locked",     32'(locked),     32'(ml));
        chk("parity_err", 32'(parity_err), 32'(mp));
    endtask

    // One clock of stimulus: check what the previous cycle produced, then present the next input.
    task automatic cycle(input logic r, input logic v, input logic [2:0] op,
                         input logic [1:0] a, input logic [7:0] d, input logic [7:0] m);
        logic       bad;
        logic       in_range;
        logic [7:0] cur;
        logic [7:0] nv;
        @(negedge clk);
        if (armed) check_all();
        rst       = r;
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                mreg[i] = RV; mlock[i] = 1'b0; mperr[i] = 1'b0; mpbad[i] = 1'b0;
            end
            exp_rv = 1'b0; exp_rd = 8'd0; exp_re = 1'b0;
            armed  = 1'b1;
        end else if (v) begin
            in_range = (int'(a) < N);
            cur      = in_range ? mreg[a] : 8'd0;
            bad      = !in_range || (op > 3'd5) || (op >= 3'd1 && op <= 3'd4 && mlock[a]);
            exp_rv   = 1'b1;
            exp_rd   = cur;
            exp_re   = bad;
            if (in_range && mpbad[a]) begin
                exp_re   = 1'b1;
                mperr[a] = 1'b1;
            end
            if (!bad) begin
                if (op >= 3'd1 && op <= 3'd4) begin
                    for (int b = 0; b < 8; b++) begin
                        nv[b] = cur[b];
                        if (m[b]) begin
                            case (op)
                                3'd1:    nv[b] = d[b];
                                3'd2:    nv[b] = cur[b] | d[b];
                                3'd3:    nv[b] = cur[b] & ~d[b];
                                default: nv[b] = cur[b] ^ d[b];
                            endcase
                        end
                    end
                    mreg[a]  = nv;
                    mpbad[a] = 1'b0;
                end else if (op == 3'd5) begin
                    mlock[a] = 1'b1;
                end
            end
        end else begin
            exp_rv = 1'b0;
        end
    endtask

    initial begin
        // Reset held for two cycles, then idle with the bank at its reset value.
        cycle(1'b1, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);

        // Masked WRITE then SET on reg1, each followed by a READ.
        cycle(1'b0, 1'b1, 3'd1, 2'd1, 8'hFF, 8'h0F);
        cycle(1'b0, 1'b1, 3'd0, 2'd1, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 3'd2, 2'd1, 8'h50, 8'hF0);
        cycle(1'b0, 1'b1, 3'd0, 2'd1, 8'h00, 8'h00);

        // Lock reg2, refused WRITE, legal READ, repeated LOCK.
        cycle(1'b0, 1'b1, 3'd5, 2'd2, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 3'd1, 2'd2, 8'h00, 8'hFF);
        cycle(1'b0, 1'b1, 3'd0, 2'd2, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 3'd5, 2'd2, 8'h00, 8'h00);

        // Out-of-range address, reserved op, zero-mask TOGGLE.
        cycle(1'b0, 1'b1, 3'd0, 2'd3, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 3'd7, 2'd0, 8'hFF, 8'hFF);
        cycle(1'b0, 1'b1, 3'd4, 2'd0, 8'hFF, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);

        // Reset together with a request: request dropped, lock cleared.
        cycle(1'b1, 1'b1, 3'd1, 2'd0, 8'h00, 8'hFF);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);

        // Random traffic including back-to-back hits, idles and occasional resets.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 8),
                  3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  8'($urandom));
        end
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);

`ifdef SYNC_RESET_REG_BANK_PARITY_EN
        // Corrupt reg0's stored parity; the next access must flag it until reset.
        cycle(1'b1, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        force dut.g_cell[0].u_cell.par_q = ~(^mreg[0]);
        mpbad[0] = 1'b1;
        cycle(1'b0, 1'b1, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        release dut.g_cell[0].u_cell.par_q;
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
